fb_scan_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 15 +
 rtl/fb_rd_pipe.sv | 33 +++
 rtl/fb_scan_arbiter.sv | 118 +++++++++++
 tb/tb_fb_scan_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry, arbiter state encoding and frame-buffer address helper.
package vga_pkg;

  localparam int H_DISP  = 640;
  localparam int V_DISP  = 480;
  localparam int H_TOTAL = 800;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  // Linear word address of pixel (x, y); worst case 307199 fits in 19 bits.
  function automatic logic [18:0] pix_addr(input logic [9:0] y, input logic [9:0] x);
    return 19'(y) * 19'(H_DISP) + 19'(x);
  endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// Delay line that realigns each issued read's valid/x tag with its SRAM data.
module fb_rd_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_vld,
  input  logic [9:0] rd_x,
  output logic       ret_vld,
  output logic [9:0] ret_x
);

  logic [RD_LAT-1:0] vld_sr;
  logic [9:0]        x_sr [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) x_sr[i] <= '0;
    end else begin
      vld_sr[0] <= rd_vld;
      x_sr[0]   <= rd_x;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        x_sr[i]   <= x_sr[i-1];
      end
    end
  end

  assign ret_vld = vld_sr[RD_LAT-1];
  assign ret_x   = x_sr[RD_LAT-1];

endmodule

// File: rtl/fb_scan_arbiter.sv
// Arbitrates one frame-buffer SRAM between display line prefetch (priority)
// and draw-port writes; fetched pixels are streamed into a ping-pong line buffer.
module fb_scan_arbiter
  import vga_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int PIX_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_line_req,
  input  logic [9:0]       i_line_y,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [9:0]       i_wr_x,
  input  logic [9:0]       i_wr_y,
  input  logic [PIX_W-1:0] i_wr_data,
  output logic [18:0]      o_mem_addr,
  output logic             o_mem_re,
  output logic             o_mem_we,
  output logic [PIX_W-1:0] o_mem_wdata,
  input  logic [PIX_W-1:0] i_mem_rdata,
  output logic             o_lb_we,
  output logic             o_lb_bank,
  output logic [9:0]       o_lb_addr,
  output logic [PIX_W-1:0] o_lb_data,
  output logic             o_busy,
  output logic             o_overrun
);

  state_t      state_q, state_d;
  logic [9:0]  line_y;
  logic [9:0]  x_cnt;
  logic [2:0]  drain_cnt;
  logic [9:0]  rd_x;
  logic        ret_vld;
  logic [9:0]  ret_x;
  logic        start;
  logic        accept;
  logic        wr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch wins a simultaneous request: ready drops while i_line_req is high.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    o_wr_ready  = rst_n && (state_q == IDLE) && !i_line_req;
    accept      = i_wr_valid && o_wr_ready;
    wr_in_range = (i_wr_x < 10'(H_DISP)) && (i_wr_y < 10'(V_DISP));
    case (state_q)
      IDLE: begin
        if (i_line_req && (i_line_y < 10'(V_DISP))) begin
          start   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH:   if (x_cnt == 10'(H_DISP - 1)) state_d = DRAIN;
      DRAIN:   if (drain_cnt == 3'(RD_LAT))  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_y      <= '0;
      o_lb_bank   <= 1'b0;
      x_cnt       <= '0;
      drain_cnt   <= '0;
      rd_x        <= '0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_overrun   <= 1'b0;
    end else begin
      o_mem_re <= 1'b0;
      o_mem_we <= 1'b0;
      if (start) begin
        line_y    <= i_line_y;
        o_lb_bank <= i_line_y[0];
        x_cnt     <= '0;
      end
      if (state_q == FETCH) begin
        o_mem_re   <= 1'b1;
        o_mem_addr <= pix_addr(line_y, x_cnt);
        rd_x       <= x_cnt;
        x_cnt      <= x_cnt + 10'd1;
      end
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      // Out-of-range draws complete the handshake but never reach memory.
      if (accept && wr_in_range) begin
        o_mem_we    <= 1'b1;
        o_mem_addr  <= pix_addr(i_wr_y, i_wr_x);
        o_mem_wdata <= i_wr_data;
      end
      if (i_line_req && (state_q != IDLE)) o_overrun <= 1'b1;
    end
  end

  fb_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_vld  (o_mem_re),
    .rd_x    (rd_x),
    .ret_vld (ret_vld),
    .ret_x   (ret_x)
  );

  assign o_busy    = (state_q != IDLE);
  assign o_lb_we   = ret_vld;
  assign o_lb_addr = ret_vld ? ret_x : 10'd0;
  assign o_lb_data = ret_vld ? i_mem_rdata : '0;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: expected memory and line-buffer traffic
// is queued when stimulus is issued and popped by a negedge monitor.
module tb_fb_scan_arbiter;

  localparam int RD_LAT = 2;
  localparam int PIX_W  = 16;
  localparam int HD     = 640;
  localparam int VD     = 480;
  localparam int BUSY_N = HD + RD_LAT + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_line_req = 1'b0;
  logic [9:0]       i_line_y = '0;
  logic             i_wr_valid = 1'b0;
  logic             o_wr_ready;
  logic [9:0]       i_wr_x = '0;
  logic [9:0]       i_wr_y = '0;
  logic [PIX_W-1:0] i_wr_data = '0;
  logic [18:0]      o_mem_addr;
  logic             o_mem_re;
  logic             o_mem_we;
  logic [PIX_W-1:0] o_mem_wdata;
  logic [PIX_W-1:0] i_mem_rdata = '0;
  logic             o_lb_we;
  logic             o_lb_bank;
  logic [9:0]       o_lb_addr;
  logic [PIX_W-1:0] o_lb_data;
  logic             o_busy;
  logic             o_overrun;

  fb_scan_arbiter #(.RD_LAT(RD_LAT), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_line_req(i_line_req), .i_line_y(i_line_y),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_x(i_wr_x), .i_wr_y(i_wr_y), .i_wr_data(i_wr_data),
    .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_lb_we(o_lb_we), .o_lb_bank(o_lb_bank), .o_lb_addr(o_lb_addr),
    .o_lb_data(o_lb_data), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #20 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int busy_start = 0;
  int busy_end   = 0;
  int lb_seen    = 0;
  logic exp_overrun = 1'b0;

  logic [18:0] exp_rd[$];
  logic [18:0] exp_wa[$];
  logic [15:0] exp_wd[$];
  logic [26:0] exp_lb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word content equals the low 16 address bits, RD_LAT latency.
  logic        sv[0:RD_LAT];
  logic [18:0] sa[0:RD_LAT];
  initial for (int i = 0; i <= RD_LAT; i++) begin sv[i] = 1'b0; sa[i] = '0; end
  always @(posedge clk) begin
    #1;
    for (int i = RD_LAT; i > 0; i--) begin sv[i] = sv[i-1]; sa[i] = sa[i-1]; end
    sv[0] = o_mem_re;
    sa[0] = o_mem_addr;
    i_mem_rdata = sv[RD_LAT] ? sa[RD_LAT][15:0] : 16'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit busy_at(input int k);
    return (k >= busy_start) && (k < busy_end);
  endfunction

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("re_we_exclusive", {o_mem_re, o_mem_we} == 2'b11, 1'b0);
      if (o_mem_re) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", o_mem_addr, exp_rd.pop_front());
      end
      if (o_mem_we) begin
        if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", o_mem_addr, exp_wa.pop_front());
          chk("wr_data", o_mem_wdata, exp_wd.pop_front());
        end
      end
      if (o_lb_we) begin
        if (exp_lb.size() == 0) chk("lb_unexpected", 1, 0);
        else begin
          chk("lb_bank_addr_data", {o_lb_bank, o_lb_addr, o_lb_data}, exp_lb.pop_front());
          lb_seen++;
        end
      end
      chk("busy", o_busy, busy_at(cyc));
      chk("overrun", o_overrun, exp_overrun);
    end
  end

  task automatic do_fetch(input logic [9:0] y, output int e);
    @(posedge clk); #1;
    i_line_req = 1'b1;
    i_line_y   = y;
    @(posedge clk); #1;
    i_line_req = 1'b0;
    e = cyc;
    if (busy_at(e - 1)) exp_overrun = 1'b1;
    else if (y < VD) begin
      busy_start = e;
      busy_end   = e + BUSY_N;
      for (int x = 0; x < HD; x++) begin
        logic [18:0] a;
        a = 19'(int'(y) * HD + x);
        exp_rd.push_back(a);
        exp_lb.push_back({y[0], 10'(x), a[15:0]});
      end
    end
  endtask

  task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d,
                          output int issue, output int acc);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    issue = cyc;
    acc = -1;
    i_wr_valid = 1'b1;
    i_wr_x = x;
    i_wr_y = y;
    i_wr_data = d;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (o_wr_ready) got = 1'b1;
    end
    if (!got) begin
      chk("wr_handshake_timeout", 0, 1);
      i_wr_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      i_wr_valid = 1'b0;
      if (x < HD && y < VD) begin
        exp_wa.push_back(19'(int'(y) * HD + int'(x)));
        exp_wd.push_back(d);
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      if (cyc > busy_end + RD_LAT + 2 && exp_rd.size() == 0 && exp_lb.size() == 0
          && exp_wa.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_wr_ready, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata, o_lb_we,
               o_lb_bank, o_lb_addr, o_lb_data, o_busy, o_overrun}, 0);
  endtask

  initial begin
    int e, e2, iss, acc;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Line 5: addresses 3200..3839 into bank 1.
    do_fetch(10'd5, e);
    wait_idle();
    chk("fetch5_lb_count", lb_seen, HD);

    // Idle draw write is accepted on the first cycle.
    do_write(10'd10, 10'd2, 16'hABCD, iss, acc);
    chk("idle_wr_latency", acc - iss, 1);
    wait_idle();

    // Simultaneous line request and write: write waits until the fetch ends.
    fork
      do_fetch(10'd9, e);
      do_write(10'd100, 10'd3, 16'h1234, iss, acc);
    join
    chk("simul_wr_accept_cycle", acc, e + BUSY_N + 1);
    wait_idle();

    // Second request 100 cycles into a fetch is an overrun, not a new fetch.
    do_fetch(10'd20, e);
    repeat (98) @(posedge clk);
    do_fetch(10'd30, e2);
    wait_idle();
    repeat (50) @(posedge clk);

    // Out-of-range line and draw are both ignored; the handshake still completes.
    do_fetch(10'd480, e);
    do_write(10'd640, 10'd5, 16'h5555, iss, acc);
    chk("oor_wr_accept", acc - iss, 1);
    do_write(10'd3, 10'd479, 16'h0F0F, iss, acc);
    wait_idle();

    // Reset around pixel 300 of a fetch abandons it completely.
    lb_seen = 0;
    do_fetch(10'd100, e);
    for (int i = 0; i < 2000 && lb_seen < 300; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midfetch_reset_outputs");
    exp_rd.delete();
    exp_lb.delete();
    busy_start = 0;
    busy_end = 0;
    exp_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    lb_seen = 0;
    do_fetch(10'd7, e);
    wait_idle();
    chk("post_reset_lb_count", lb_seen, HD);

    // Randomized traffic: a draw stream interleaved with spaced line requests.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          do_write(10'($urandom_range(0, 700)), 10'($urandom_range(0, 520)),
                   16'($urandom), iss, acc);
          repeat ($urandom_range(0, 30)) @(posedge clk);
        end
      end
      begin
        for (int n = 0; n < 3; n++) begin
          repeat ($urandom_range(700, 900)) @(posedge clk);
          do_fetch(10'($urandom_range(0, 500)), e);
        end
      end
    join
    wait_idle();

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("lb_queue_empty", exp_lb.size(), 0);
    chk("wr_queue_empty", exp_wa.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
